// File: rtl/eq_lookup_sched_pkg.sv
// Shared constants, width helpers and the registered response record for eq_lookup_sched.
// resp_t is sized for the default build (6-bit IDs, 8 entries, 3 requesters).
package eq_lookup_pkg;

  localparam int DEF_ID_WIDTH = 6;
  localparam int DEF_NUM_ID   = 8;
  localparam int DEF_NUM_REQ  = 3;

  // All-ones pattern of the given width; reserved to mark an empty table entry.
  function automatic logic [31:0] invalid_id(input int id_width);
    return (32'd1 << id_width) - 32'd1;
  endfunction

  // Result index needs one extra code point: NUM_ID means "no match".
  function automatic int idx_width(input int num_id);
    return $clog2(num_id + 1);
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_NUM_ID);
  localparam int DEF_REQ_W = sel_width(DEF_NUM_REQ);

  typedef struct packed {
    logic                  valid;
    logic [DEF_REQ_W-1:0]  req;
    logic                  hit;
    logic [DEF_IDX_W-1:0]  idx;
    logic [DEF_NUM_ID-1:0] vec;
  } resp_t;

endpackage

// File: rtl/eq_lookup_sched_if.sv
// Lookup request/response, table-update and flush signals of eq_lookup_sched.
// slave = the scheduler side, master = clients and table owner.
interface eq_lookup_sched_if
  import eq_lookup_pkg::*;
#(
  parameter int ID_WIDTH = DEF_ID_WIDTH,
  parameter int NUM_ID   = DEF_NUM_ID,
  parameter int NUM_REQ  = DEF_NUM_REQ
) ();
  localparam int IDX_W  = idx_width(NUM_ID);
  localparam int REQ_W  = sel_width(NUM_REQ);
  localparam int TIDX_W = sel_width(NUM_ID);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*ID_WIDTH-1:0] req_id;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        resp_valid;
  logic [REQ_W-1:0]            resp_req;
  logic                        resp_hit;
  logic [IDX_W-1:0]            resp_idx;
  logic [NUM_ID-1:0]           resp_vec;
  logic                        wr_en;
  logic [TIDX_W-1:0]           wr_idx;
  logic [ID_WIDTH-1:0]         wr_id;
  logic                        inv_en;
  logic [TIDX_W-1:0]           inv_idx;
  logic                        flush;

  modport slave (
    input  req_valid, req_id, wr_en, wr_idx, wr_id, inv_en, inv_idx, flush,
    output req_ready, resp_valid, resp_req, resp_hit, resp_idx, resp_vec
  );

  modport master (
    output req_valid, req_id, wr_en, wr_idx, wr_id, inv_en, inv_idx, flush,
    input  req_ready, resp_valid, resp_req, resp_hit, resp_idx, resp_vec
  );

endinterface

// File: rtl/eq_comp.sv
// Parallel equality compare of one ID against a flattened table; lowest matching index wins.
// Purely combinational, no state.
module eq_comp #(
  parameter  int ID_WIDTH  = 6,
  parameter  int NUM_ID    = 8,
  localparam int IDX_WIDTH = $clog2(NUM_ID + 1)
) (
  input  logic [ID_WIDTH-1:0]        id,
  input  logic [NUM_ID*ID_WIDTH-1:0] id_array,
  output logic [NUM_ID-1:0]          eq_vec,
  output logic                       hit,
  output logic [IDX_WIDTH-1:0]       idx
);

  always_comb begin
    eq_vec = '0;
    hit    = 1'b0;
    idx    = IDX_WIDTH'(NUM_ID);
    // Descending scan so the lowest matching entry is the last one written.
    for (int i = NUM_ID - 1; i >= 0; i--) begin
      eq_vec[i] = (id_array[i*ID_WIDTH +: ID_WIDTH] == id);
      if (eq_vec[i]) idx = IDX_WIDTH'(i);
    end
    hit = |eq_vec;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last one served.
// Combinational grant, pointer advances on the clock edge of each grant; en=0 blocks all grants.
module rr_arbiter
  import eq_lookup_pkg::*;
#(
  parameter  int N  = 3,
  localparam int SW = sel_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic [SW-1:0] ptr_q;
  logic [SW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = SW'((int'(ptr_q) + i) % N);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset to N-1 so requester 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SW'(N - 1);
    end else if (found) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/eq_lookup_sched.sv
// Shares one eq_comp among NUM_REQ requesters against an owned ID table; result registered, 1-cycle latency.
// No response backpressure; flush blocks grants and drops the pending result. Option macro: EQ_LOOKUP_BYPASS_EN.
module eq_lookup_sched
  import eq_lookup_pkg::*;
#(
  parameter int ID_WIDTH = DEF_ID_WIDTH,
  parameter int NUM_ID   = DEF_NUM_ID,
  parameter int NUM_REQ  = DEF_NUM_REQ
) (
  input logic              clk,
  input logic              rst_n,
  eq_lookup_sched_if.slave bus
);

  localparam int IDX_WIDTH = idx_width(NUM_ID);
  localparam int REQ_W     = sel_width(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] INVALID_ID = ID_WIDTH'(invalid_id(ID_WIDTH));

  logic [ID_WIDTH-1:0]        table_q [NUM_ID];
  logic [ID_WIDTH-1:0]        table_d [NUM_ID];
  logic [NUM_ID*ID_WIDTH-1:0] cmp_array;
  logic [NUM_REQ-1:0]         grant;
  logic [REQ_W-1:0]           grant_idx;
  logic [ID_WIDTH-1:0]        sel_id;
  logic                       sel_invalid;
  logic                       cmp_hit;
  logic [IDX_WIDTH-1:0]       cmp_idx;
  logic [NUM_ID-1:0]          cmp_vec;
  resp_t                      resp_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (rst_n & ~bus.flush),
    .req       (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;

  // Post-update table view: invalidate is applied after write so it wins on the same index.
  always_comb begin
    for (int i = 0; i < NUM_ID; i++) begin
      table_d[i] = table_q[i];
      if (bus.wr_en && (int'(bus.wr_idx) == i)) table_d[i] = bus.wr_id;
      if (bus.inv_en && (int'(bus.inv_idx) == i)) table_d[i] = INVALID_ID;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ID; i++) table_q[i] <= INVALID_ID;
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_ID; i++) table_q[i] <= INVALID_ID;
    end else begin
      for (int i = 0; i < NUM_ID; i++) table_q[i] <= table_d[i];
    end
  end

  always_comb begin
    cmp_array = '0;
    for (int i = 0; i < NUM_ID; i++) begin
`ifdef EQ_LOOKUP_BYPASS_EN
      cmp_array[i*ID_WIDTH +: ID_WIDTH] = table_d[i];
`else
      cmp_array[i*ID_WIDTH +: ID_WIDTH] = table_q[i];
`endif
    end
  end

  assign sel_id      = bus.req_id[grant_idx*ID_WIDTH +: ID_WIDTH];
  assign sel_invalid = (sel_id == INVALID_ID);

  eq_comp #(.ID_WIDTH(ID_WIDTH), .NUM_ID(NUM_ID)) u_eq_comp (
    .id       (sel_id),
    .id_array (cmp_array),
    .eq_vec   (cmp_vec),
    .hit      (cmp_hit),
    .idx      (cmp_idx)
  );

  // An INVALID_ID probe would match every empty entry, so its result is forced to a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q.valid <= 1'b0;
      resp_q.req   <= '0;
      resp_q.hit   <= 1'b0;
      resp_q.idx   <= IDX_WIDTH'(NUM_ID);
      resp_q.vec   <= '0;
    end else begin
      resp_q.valid <= |grant;
      if (|grant) begin
        resp_q.req <= grant_idx;
        resp_q.hit <= cmp_hit & ~sel_invalid;
        resp_q.idx <= sel_invalid ? IDX_WIDTH'(NUM_ID) : cmp_idx;
        resp_q.vec <= sel_invalid ? '0 : cmp_vec;
      end
    end
  end

  // A flush in the response cycle kills the result of the lookup accepted just before it.
  assign bus.resp_valid = resp_q.valid & ~bus.flush;
  assign bus.resp_req   = resp_q.req;
  assign bus.resp_hit   = resp_q.hit;
  assign bus.resp_idx   = resp_q.idx;
  assign bus.resp_vec   = resp_q.vec;

endmodule

// File: tb/tb_eq_lookup_sched.sv
// Bench for eq_lookup_sched: directed scenarios plus randomized traffic against a table/queue model.
module tb_eq_lookup_sched;

  localparam logic [5:0] INV = 6'h3F;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  eq_lookup_sched_if #(.ID_WIDTH(6), .NUM_ID(8), .NUM_REQ(3)) bus ();

  eq_lookup_sched #(.ID_WIDTH(6), .NUM_ID(8), .NUM_REQ(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic idle();
    bus.req_valid = '0;
    bus.req_id    = '0;
    bus.wr_en     = 1'b0;
    bus.wr_idx    = '0;
    bus.wr_id     = '0;
    bus.inv_en    = 1'b0;
    bus.inv_idx   = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [5:0] id);
    bus.req_valid[r]      = 1'b1;
    bus.req_id[r*6 +: 6]  = id;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [5:0] pick_id();
    int v = $urandom_range(0, 8);
    return (v == 8) ? INV : 6'(v);
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    idle();
    #1 rst_n = 1'b0;
    bus.req_valid = 3'b111;
    #2;
    n_cmp++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    n_cmp++; if (bus.resp_req !== 2'd0) begin n_err++; $display("FAIL reset_resp_req got=%0d exp=0", bus.resp_req); end
    n_cmp++; if (bus.resp_hit !== 1'b0) begin n_err++; $display("FAIL reset_resp_hit got=%b exp=0", bus.resp_hit); end
    n_cmp++; if (bus.resp_idx !== 4'd8) begin n_err++; $display("FAIL reset_resp_idx got=%0d exp=8", bus.resp_idx); end
    n_cmp++; if (bus.resp_vec !== 8'h00) begin n_err++; $display("FAIL reset_resp_vec got=%h exp=00", bus.resp_vec); end
    tick();
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_lookup_miss();
    idle();
    set_req(0, 6'd5);
    #3;
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL miss_ready got=%b exp=001", bus.req_ready); end
    tick();
    idle();
    #3;
    n_cmp++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL miss_valid got=%b exp=1", bus.resp_valid); end
    n_cmp++; if (bus.resp_req !== 2'd0) begin n_err++; $display("FAIL miss_req got=%0d exp=0", bus.resp_req); end
    n_cmp++; if (bus.resp_hit !== 1'b0) begin n_err++; $display("FAIL miss_hit got=%b exp=0", bus.resp_hit); end
    n_cmp++; if (bus.resp_idx !== 4'd8) begin n_err++; $display("FAIL miss_idx got=%0d exp=8", bus.resp_idx); end
    n_cmp++; if (bus.resp_vec !== 8'h00) begin n_err++; $display("FAIL miss_vec got=%h exp=00", bus.resp_vec); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (dut.table_q[i] !== INV) begin n_err++; $display("FAIL reset_table[%0d] got=%h exp=3f", i, dut.table_q[i]); end
    end
    tick();
  endtask

  task automatic test_hit_lowest();
    idle();
    bus.wr_en = 1'b1; bus.wr_idx = 3'd2; bus.wr_id = 6'd9;
    tick();
    bus.wr_idx = 3'd6;
    tick();
    idle();
    set_req(0, 6'd9);
    #3;
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL hit_ready got=%b exp=001", bus.req_ready); end
    tick();
    idle();
    #3;
    n_cmp++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL hit_valid got=%b exp=1", bus.resp_valid); end
    n_cmp++; if (bus.resp_hit !== 1'b1) begin n_err++; $display("FAIL hit_hit got=%b exp=1", bus.resp_hit); end
    n_cmp++; if (bus.resp_idx !== 4'd2) begin n_err++; $display("FAIL hit_idx got=%0d exp=2", bus.resp_idx); end
    n_cmp++; if (bus.resp_vec !== 8'h44) begin n_err++; $display("FAIL hit_vec got=%h exp=44", bus.resp_vec); end
    bus.inv_en = 1'b1; bus.inv_idx = 3'd2;
    tick();
    idle();
    set_req(0, 6'd9);
    tick();
    idle();
    #3;
    n_cmp++; if (bus.resp_hit !== 1'b1) begin n_err++; $display("FAIL hit2_hit got=%b exp=1", bus.resp_hit); end
    n_cmp++; if (bus.resp_idx !== 4'd6) begin n_err++; $display("FAIL hit2_idx got=%0d exp=6", bus.resp_idx); end
    n_cmp++; if (bus.resp_vec !== 8'h40) begin n_err++; $display("FAIL hit2_vec got=%h exp=40", bus.resp_vec); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] eg;
    logic [1:0] er;
    do_reset();
    idle();
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      bus.req_id = 18'($urandom);
      eg = 3'b001 << (k % 3);
      #3;
      n_cmp++; if (bus.req_ready !== eg) begin n_err++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus.req_ready, eg); end
      if (k > 0) begin
        er = 2'((k - 1) % 3);
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_req !== er) begin
          n_err++; $display("FAIL rr_resp[%0d] got=%b/%0d exp=1/%0d", k, bus.resp_valid, bus.resp_req, er);
        end
      end
      tick();
    end
    bus.req_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0) ? 3'b001 : 3'b100;
      er = (k % 2 == 1) ? 2'd0 : 2'd2;
      #3;
      n_cmp++; if (bus.req_ready !== eg) begin n_err++; $display("FAIL rr101_ready[%0d] got=%b exp=%b", k, bus.req_ready, eg); end
      n_cmp++; if (bus.resp_req !== er) begin n_err++; $display("FAIL rr101_req[%0d] got=%0d exp=%0d", k, bus.resp_req, er); end
      tick();
    end
    idle();
  endtask

  task automatic test_bypass();
    logic       eh;
    logic [3:0] ei;
    logic [7:0] ev;
`ifdef EQ_LOOKUP_BYPASS_EN
    eh = 1'b1; ei = 4'd3; ev = 8'h08;
`else
    eh = 1'b0; ei = 4'd8; ev = 8'h00;
`endif
    idle();
    bus.wr_en = 1'b1; bus.wr_idx = 3'd3; bus.wr_id = 6'd12;
    set_req(0, 6'd12);
    #3;
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL byp_ready got=%b exp=001", bus.req_ready); end
    tick();
    idle();
    set_req(0, 6'd12);
    #3;
    n_cmp++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL byp_valid got=%b exp=1", bus.resp_valid); end
    n_cmp++; if (bus.resp_hit !== eh) begin n_err++; $display("FAIL byp_hit got=%b exp=%b", bus.resp_hit, eh); end
    n_cmp++; if (bus.resp_idx !== ei) begin n_err++; $display("FAIL byp_idx got=%0d exp=%0d", bus.resp_idx, ei); end
    n_cmp++; if (bus.resp_vec !== ev) begin n_err++; $display("FAIL byp_vec got=%h exp=%h", bus.resp_vec, ev); end
    tick();
    idle();
    bus.wr_en = 1'b1; bus.wr_idx = 3'd3; bus.wr_id = 6'd20;
    bus.inv_en = 1'b1; bus.inv_idx = 3'd3;
    set_req(0, 6'd20);
    #3;
    n_cmp++; if (bus.resp_hit !== 1'b1 || bus.resp_idx !== 4'd3) begin
      n_err++; $display("FAIL byp_next got=%b/%0d exp=1/3", bus.resp_hit, bus.resp_idx);
    end
    tick();
    idle();
    #3;
    n_cmp++; if (bus.resp_hit !== 1'b0 || bus.resp_idx !== 4'd8 || bus.resp_vec !== 8'h00) begin
      n_err++; $display("FAIL wrinv_resp got=%b/%0d/%h exp=0/8/00", bus.resp_hit, bus.resp_idx, bus.resp_vec);
    end
    n_cmp++; if (dut.table_q[3] !== INV) begin n_err++; $display("FAIL wrinv_entry got=%h exp=3f", dut.table_q[3]); end
    tick();
  endtask

  task automatic test_flush();
    idle();
    bus.wr_en = 1'b1; bus.wr_idx = 3'd0; bus.wr_id = 6'd7;
    tick();
    idle();
    set_req(0, 6'd7);
    #3;
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL flush_pre_ready got=%b exp=001", bus.req_ready); end
    tick();
    idle();
    bus.flush = 1'b1;
    bus.req_valid = 3'b111;
    #3;
    n_cmp++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL flush_ready got=%b exp=000", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got=%b exp=0", bus.resp_valid); end
    tick();
    idle();
    #3;
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_after got=%b exp=0", bus.resp_valid); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (dut.table_q[i] !== INV) begin n_err++; $display("FAIL flush_table[%0d] got=%h exp=3f", i, dut.table_q[i]); end
    end
    set_req(1, 6'd7);
    #1;
    n_cmp++; if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL flush_resume got=%b exp=010", bus.req_ready); end
    tick();
    idle();
    #3;
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_req !== 2'd1 || bus.resp_hit !== 1'b0) begin
      n_err++; $display("FAIL flush_resume_resp got=%b/%0d/%b exp=1/1/0", bus.resp_valid, bus.resp_req, bus.resp_hit);
    end
    tick();
  endtask

  task automatic test_invalid_and_reset();
    idle();
    set_req(2, INV);
    #3;
    n_cmp++; if (bus.req_ready !== 3'b100) begin n_err++; $display("FAIL inv_ready got=%b exp=100", bus.req_ready); end
    tick();
    idle();
    #3;
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_req !== 2'd2) begin
      n_err++; $display("FAIL inv_resp got=%b/%0d exp=1/2", bus.resp_valid, bus.resp_req);
    end
    n_cmp++; if (bus.resp_hit !== 1'b0 || bus.resp_idx !== 4'd8 || bus.resp_vec !== 8'h00) begin
      n_err++; $display("FAIL inv_forced got=%b/%0d/%h exp=0/8/00", bus.resp_hit, bus.resp_idx, bus.resp_vec);
    end
    bus.wr_en = 1'b1; bus.wr_idx = 3'd1; bus.wr_id = 6'd33;
    tick();
    idle();
    set_req(0, 6'd33);
    #3;
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL midrst_ready got=%b exp=001", bus.req_ready); end
    tick();
    idle();
    bus.req_valid = 3'b111;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.resp_valid !== 1'b0 || bus.resp_hit !== 1'b0 || bus.resp_idx !== 4'd8) begin
      n_err++; $display("FAIL midrst_resp got=%b/%b/%0d exp=0/0/8", bus.resp_valid, bus.resp_hit, bus.resp_idx);
    end
    n_cmp++; if (bus.resp_vec !== 8'h00 || bus.resp_req !== 2'd0) begin
      n_err++; $display("FAIL midrst_vec got=%h/%0d exp=00/0", bus.resp_vec, bus.resp_req);
    end
    n_cmp++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL midrst_grant got=%b exp=000", bus.req_ready); end
    n_cmp++; if (dut.table_q[1] !== INV) begin n_err++; $display("FAIL midrst_table got=%h exp=3f", dut.table_q[1]); end
    tick();
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  // Model: table contents, last-served requester, and the response owed next cycle.
  task automatic test_random();
    logic [5:0] mtab [8];
    logic [5:0] view [8];
    int         last;
    int         gid;
    logic [2:0] eg;
    logic [5:0] gi;
    logic       pv;
    logic [1:0] preq;
    logic       phit;
    logic [3:0] pidx;
    logic [7:0] pvec;
    do_reset();
    for (int i = 0; i < 8; i++) mtab[i] = INV;
    last = 2; pv = 1'b0; preq = 2'd0; phit = 1'b0; pidx = 4'd8; pvec = 8'h00;
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = 3'($urandom);
      for (int r = 0; r < 3; r++) bus.req_id[r*6 +: 6] = pick_id();
      bus.wr_en   = ($urandom_range(0, 9) < 4);
      bus.wr_idx  = 3'($urandom);
      bus.wr_id   = pick_id();
      bus.inv_en  = ($urandom_range(0, 9) < 2);
      bus.inv_idx = 3'($urandom);
      bus.flush   = ($urandom_range(0, 29) == 0);
      gid = -1;
      if (!bus.flush) begin
        for (int k = 1; k <= 3; k++) begin
          int j = (last + k) % 3;
          if (gid < 0 && bus.req_valid[j]) gid = j;
        end
      end
      eg = (gid >= 0) ? (3'b001 << gid) : 3'b000;
      #3;
      n_cmp++; if (bus.req_ready !== eg) begin n_err++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, bus.req_ready, eg); end
      n_cmp++; if (bus.resp_valid !== (pv & ~bus.flush)) begin
        n_err++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, bus.resp_valid, pv & ~bus.flush);
      end
      if (pv && !bus.flush) begin
        n_cmp++; if (bus.resp_req !== preq || bus.resp_hit !== phit || bus.resp_idx !== pidx || bus.resp_vec !== pvec) begin
          n_err++; $display("FAIL rnd_resp[%0d] got=%0d/%b/%0d/%h exp=%0d/%b/%0d/%h", c, bus.resp_req, bus.resp_hit,
                            bus.resp_idx, bus.resp_vec, preq, phit, pidx, pvec);
        end
      end
      for (int i = 0; i < 8; i++) view[i] = mtab[i];
`ifdef EQ_LOOKUP_BYPASS_EN
      if (bus.wr_en) view[bus.wr_idx] = bus.wr_id;
      if (bus.inv_en) view[bus.inv_idx] = INV;
`endif
      pv = (gid >= 0);
      if (gid >= 0) begin
        gi   = bus.req_id[gid*6 +: 6];
        preq = 2'(gid);
        last = gid;
        for (int i = 0; i < 8; i++) pvec[i] = (gi != INV) && (view[i] == gi);
        phit = |pvec;
        pidx = 4'd8;
        for (int i = 7; i >= 0; i--) if (pvec[i]) pidx = 4'(i);
      end
      if (bus.flush) begin
        for (int i = 0; i < 8; i++) mtab[i] = INV;
      end else begin
        if (bus.wr_en) mtab[bus.wr_idx] = bus.wr_id;
        if (bus.inv_en) mtab[bus.inv_idx] = INV;
      end
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_lookup_miss();
    test_hit_lowest();
    test_round_robin();
    test_bypass();
    test_flush();
    test_invalid_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
